// File: rtl/hiscore_upload.sv
// Upload responder for the HPS ioctl channel: serves ioctl_rd strobes from a
// core-side byte RAM, holding the HPS off with ioctl_wait while the RAM port is busy.
module hiscore_upload #(
    parameter int          ADDR_W   = 10,
    parameter logic [7:0]  UP_INDEX = 8'd4,
    parameter int          RD_LAT   = 1
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic [7:0]        ioctl_index,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    output logic              pause_req,
    input  logic              cpu_busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    input  logic [7:0]        ram_dout,
    output logic              overrun
);

    localparam int CNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARB  = 2'd1,
        READ = 2'd2,
        CAPT = 2'd3
    } state_t;

    state_t             state_r;
    logic [24:0]        areg_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               sel_r;
    logic               sel_s;
    logic               strobe_s;
    logic               in_range_s;

    // Transfer selection and address range decode.
    always_comb begin
        sel_s      = ioctl_upload && (ioctl_index == UP_INDEX);
        strobe_s   = sel_s && ioctl_rd;
        in_range_s = ((areg_r >> ADDR_W) == 25'd0);
    end

    // Read sequencer: latch strobe, arbitrate for the RAM port, wait out latency, capture.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_r    <= IDLE;
            areg_r     <= 25'd0;
            cnt_r      <= {CNT_W{1'b0}};
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            ram_addr   <= {ADDR_W{1'b0}};
            ram_rd     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (strobe_s) begin
                        areg_r     <= ioctl_addr;
                        ioctl_wait <= 1'b1;
                        state_r    <= ARB;
                    end
                end
                ARB: begin
                    if (!in_range_s) begin
                        // Nothing lives out there; answer zero without touching the RAM.
                        ioctl_din  <= 8'h00;
                        ioctl_wait <= 1'b0;
                        state_r    <= IDLE;
                    end else if (!cpu_busy) begin
                        ram_addr <= areg_r[ADDR_W-1:0];
                        ram_rd   <= 1'b1;
                        cnt_r    <= CNT_W'(RD_LAT);
                        state_r  <= READ;
                    end
                end
                READ: begin
                    ram_rd <= 1'b0;
                    if (cnt_r <= CNT_W'(1)) begin
                        state_r <= CAPT;
                    end else begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end
                end
                CAPT: begin
                    ioctl_din  <= ram_dout;
                    ioctl_wait <= 1'b0;
                    state_r    <= IDLE;
                end
                default: begin
                    ioctl_wait <= 1'b0;
                    ram_rd     <= 1'b0;
                    state_r    <= IDLE;
                end
            endcase
        end
    end

    // Upload-wide status: CPU pause request and sticky overrun flag.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sel_r     <= 1'b0;
            overrun   <= 1'b0;
            pause_req <= 1'b0;
        end else begin
            sel_r <= sel_s;
            if (strobe_s && (state_r != IDLE)) begin
                overrun <= 1'b1;
            end else if (sel_s && !sel_r) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
            // Pause is held until any in-flight read has returned to IDLE.
            if (sel_s && sel_r) begin
                pause_req <= 1'b1;
            end else if (!sel_s && (state_r == IDLE)) begin
                pause_req <= 1'b0;
            end else begin
                pause_req <= pause_req;
            end
        end
    end

endmodule

// File: tb/tb_hiscore_upload.sv
// Directed bench for hiscore_upload: a vector table of single reads plus
// hand-written overrun, pause and reset sequences against a 1-cycle RAM model.
module tb_hiscore_upload;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_upload;
    logic [7:0]  ioctl_index;
    logic        ioctl_rd;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_din;
    logic        ioctl_wait;
    logic        pause_req;
    logic        cpu_busy;
    logic [9:0]  ram_addr;
    logic        ram_rd;
    logic [7:0]  ram_dout = 8'h00;
    logic        overrun;

    logic [7:0]  mem [0:1023];

    int n_chk  = 0;
    int n_fail = 0;

    hiscore_upload #(.ADDR_W(10), .UP_INDEX(8'd4), .RD_LAT(1)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .ioctl_upload (ioctl_upload),
        .ioctl_index  (ioctl_index),
        .ioctl_rd     (ioctl_rd),
        .ioctl_addr   (ioctl_addr),
        .ioctl_din    (ioctl_din),
        .ioctl_wait   (ioctl_wait),
        .pause_req    (pause_req),
        .cpu_busy     (cpu_busy),
        .ram_addr     (ram_addr),
        .ram_rd       (ram_rd),
        .ram_dout     (ram_dout),
        .overrun      (overrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous RAM, one cycle of read latency.
    always @(posedge clk_sys) begin
        if (ram_rd) ram_dout <= mem[ram_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one strobe and follow it until ioctl_wait drops (bounded).
    task automatic do_read(input logic [24:0] addr, input int busy,
                           output int wcyc, output int rds, output logic [9:0] raddr);
        @(negedge clk_sys);
        ioctl_addr = addr;
        ioctl_rd   = 1'b1;
        cpu_busy   = (busy > 0);
        wcyc  = 0;
        rds   = 0;
        raddr = 10'd0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk_sys);
            @(negedge clk_sys);
            ioctl_rd = 1'b0;
            cpu_busy = (k + 1 <= busy);
            if (ram_rd) begin
                rds++;
                raddr = ram_addr;
            end
            if (ioctl_wait) wcyc++;
            else break;
        end
    endtask

    typedef struct {
        logic [24:0] addr;
        int          busy;
        logic [7:0]  din;
        int          wcyc;
        int          rds;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int          wcyc;
        int          rds;
        logic [9:0]  raddr;
        logic [9:0]  exp_ra;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h012] = 8'hA5;
        mem[10'h3FF] = 8'h5C;
        mem[10'h000] = 8'h11;
        mem[10'h2A0] = 8'h3C;

        vecs[0] = '{25'h0000012, 0, 8'hA5, 3, 1};
        vecs[1] = '{25'h00003FF, 0, 8'h5C, 3, 1};
        vecs[2] = '{25'h0000000, 2, 8'h11, 5, 1};
        vecs[3] = '{25'h0000012, 5, 8'hA5, 8, 1};
        vecs[4] = '{25'h0000400, 0, 8'h00, 1, 0};
        vecs[5] = '{25'h1FFFFFF, 0, 8'h00, 1, 0};
        vecs[6] = '{25'h00002A0, 1, 8'h3C, 4, 1};

        reset        = 1'b1;
        ioctl_upload = 1'b0;
        ioctl_index  = 8'd0;
        ioctl_rd     = 1'b0;
        ioctl_addr   = 25'd0;
        cpu_busy     = 1'b0;
        #12;
        check("rst_din",     32'(ioctl_din),  32'h00);
        check("rst_wait",    32'(ioctl_wait), 32'h0);
        check("rst_pause",   32'(pause_req),  32'h0);
        check("rst_ram_rd",  32'(ram_rd),     32'h0);
        check("rst_ram_addr",32'(ram_addr),   32'h0);
        check("rst_overrun", 32'(overrun),    32'h0);
        @(negedge clk_sys);
        reset        = 1'b0;
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd4;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("pause_on", 32'(pause_req), 32'h1);

        // Table of single reads.
        for (int i = 0; i < 7; i++) begin
            do_read(vecs[i].addr, vecs[i].busy, wcyc, rds, raddr);
            check($sformatf("v%0d_wait_cycles", i), 32'(wcyc), 32'(vecs[i].wcyc));
            check($sformatf("v%0d_ram_rd_count", i), 32'(rds), 32'(vecs[i].rds));
            check($sformatf("v%0d_din", i), 32'(ioctl_din), 32'(vecs[i].din));
            if (vecs[i].rds > 0) begin
                exp_ra = vecs[i].addr[9:0];
                check($sformatf("v%0d_ram_addr", i), 32'(raddr), 32'(exp_ra));
            end
        end
        check("table_no_overrun", 32'(overrun), 32'h0);

        // Second strobe one cycle after the first is dropped.
        @(negedge clk_sys);
        ioctl_addr = 25'h012;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_addr = 25'h3FF;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("ovr_set", 32'(overrun), 32'h1);
        rds = 0;
        for (int k = 0; k < 20; k++) begin
            if (ram_rd) begin
                rds++;
                raddr = ram_addr;
            end
            if (!ioctl_wait) break;
            @(posedge clk_sys);
            @(negedge clk_sys);
        end
        check("ovr_wait_done", 32'(ioctl_wait), 32'h0);
        check("ovr_rd_count", 32'(rds), 32'h1);
        check("ovr_ram_addr", 32'(raddr), 32'h012);
        check("ovr_din", 32'(ioctl_din), 32'hA5);
        ioctl_upload = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("ovr_sticky", 32'(overrun), 32'h1);
        ioctl_upload = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("ovr_clear", 32'(overrun), 32'h0);

        // Strobe at the edge ioctl_wait falls is busy; one edge later is accepted.
        ioctl_addr = 25'h2A0;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_addr = 25'h000;
        ioctl_rd   = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("edge_wait_low", 32'(ioctl_wait), 32'h0);
        check("edge_overrun", 32'(overrun), 32'h1);
        check("edge_din", 32'(ioctl_din), 32'h3C);
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("next_accepted", 32'(ioctl_wait), 32'h1);
        for (int k = 0; k < 20; k++) begin
            if (!ioctl_wait) break;
            @(posedge clk_sys);
            @(negedge clk_sys);
        end
        check("next_din", 32'(ioctl_din), 32'h11);

        // Index filter, pause timing, upload falling mid-read.
        ioctl_upload = 1'b0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        check("pause_off", 32'(pause_req), 32'h0);
        ioctl_upload = 1'b1;
        ioctl_index  = 8'd0;
        ioctl_addr   = 25'h012;
        ioctl_rd     = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("idx_no_wait", 32'(ioctl_wait), 32'h0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("idx_no_pause", 32'(pause_req), 32'h0);
        check("idx_no_rd", 32'(ram_rd), 32'h0);
        ioctl_index = 8'd4;
        ioctl_rd    = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        check("sel_rise_wait", 32'(ioctl_wait), 32'h1);
        check("sel_rise_pause0", 32'(pause_req), 32'h0);
        check("sel_rise_ovr_clr", 32'(overrun), 32'h0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("sel_rise_pause1", 32'(pause_req), 32'h1);
        check("mid_ram_rd", 32'(ram_rd), 32'h1);
        ioctl_upload = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        check("mid_wait_done", 32'(ioctl_wait), 32'h0);
        check("mid_din", 32'(ioctl_din), 32'hA5);
        check("mid_pause_held", 32'(pause_req), 32'h1);
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("mid_pause_drop", 32'(pause_req), 32'h0);

        // Reset while arbitrating with the core holding the RAM port.
        ioctl_upload = 1'b1;
        cpu_busy     = 1'b1;
        ioctl_addr   = 25'h3FF;
        ioctl_rd     = 1'b1;
        @(posedge clk_sys);
        @(negedge clk_sys);
        ioctl_rd = 1'b0;
        @(posedge clk_sys);
        @(negedge clk_sys);
        check("arb_wait", 32'(ioctl_wait), 32'h1);
        check("arb_pause", 32'(pause_req), 32'h1);
        #1;
        reset = 1'b1;
        #1;
        check("mrst_wait",     32'(ioctl_wait), 32'h0);
        check("mrst_din",      32'(ioctl_din),  32'h00);
        check("mrst_pause",    32'(pause_req),  32'h0);
        check("mrst_ram_rd",   32'(ram_rd),     32'h0);
        check("mrst_ram_addr", 32'(ram_addr),   32'h0);
        check("mrst_overrun",  32'(overrun),    32'h0);
        @(negedge clk_sys);
        reset    = 1'b0;
        cpu_busy = 1'b0;
        do_read(25'h3FF, 0, wcyc, rds, raddr);
        check("post_rst_wait", 32'(wcyc), 32'h3);
        check("post_rst_rds", 32'(rds), 32'h1);
        check("post_rst_addr", 32'(raddr), 32'h3FF);
        check("post_rst_din", 32'(ioctl_din), 32'h5C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
